fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of first fetch after reset; bits [1:0] SHALL be 0.
REQ-002 Clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 PC_sel  input  1  next-PC select: 0 = PC+4, 1 = PC+4+(Immed<<2).
REQ-005 Immed  input  32  sign-extended immediate from the decode stage.
REQ-006 PC_LdEn  input  1  decode stage accepts the presented instruction.
REQ-007 Imem_req  output  1  instruction-memory read request.
REQ-008 Imem_addr  output  32  instruction-memory word address, byte-addressed.
REQ-009 Imem_ready  input  1  memory returns data this cycle.
REQ-010 Imem_rdata  input  32  memory read data.
REQ-011 Instr  output  32  fetched instruction presented to decode.
REQ-012 Instr_valid  output  1  Instr and PC are valid.
REQ-013 PC  output  32  address of the instruction currently held or being fetched.

Function
REQ-014 FSM SHALL have states IDLE, REQ and HOLD; IDLE->REQ unconditionally on the first edge after reset release.
REQ-015 In REQ: Imem_req=1 and Imem_addr=PC, both held stable until Imem_ready=1.
REQ-016 REQ->HOLD on the edge where Imem_ready=1; Imem_rdata SHALL be captured into Instr on that edge.
REQ-017 In HOLD: Instr_valid=1 and Imem_req=0; Imem_ready SHALL be ignored outside REQ.
REQ-018 Accept = HOLD & PC_LdEn; on accept, PC <= next PC per PC_sel/Immed sampled that cycle, and state <= REQ.
REQ-019 PC_LdEn SHALL be ignored while Instr_valid=0.
REQ-020 Latency: accept at edge N gives Imem_req=1 in cycle N+1; with a zero-wait memory, Instr_valid=1 in cycle N+2.
REQ-021 Next-PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000; bits [1:0] SHALL be forced to 0.
REQ-022 Instr and PC SHALL remain stable while HOLD persists without accept.

Reset
REQ-023 reset low SHALL immediately force state=IDLE, PC=RESET_PC, Instr=0, Instr_valid=0 and Imem_req=0, including mid-request; the outstanding request is abandoned.
REQ-024 A late Imem_ready arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-025 Macro FETCH_PERF_CNT_EN, when defined, SHALL add outputs Fetch_cnt[31:0] (accepts) and Stall_cnt[31:0] (cycles with Instr_valid=1 & PC_LdEn=0); both reset to 0 and saturate at 32'hFFFF_FFFF.
REQ-026 Without FETCH_PERF_CNT_EN, these ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-027 Shared package fetch_pkg SHALL hold the state encodings (IDLE/REQ/HOLD), the PC increment constant 4 and the default RESET_PC.
REQ-028 Next-PC computation SHALL be a combinational sub-module fetch_pc_adder (inputs PC, Immed, PC_sel; output next PC).

Verification
REQ-029 Reset release with RESET_PC=0 and Imem_ready tied to 1 -> Imem_req=1 with Imem_addr=0 one cycle after release; Instr_valid=1 the next cycle.
REQ-030 Sequential run, PC_sel=0, PC_LdEn=1, zero-wait memory -> addresses 0, 4, 8, 12; each Instr equals the memory word at its PC.
REQ-031 Branch: at PC=0x100 accept with PC_sel=1 and Immed=0xFFFF_FFFE -> next Imem_addr=0x0FC.
REQ-032 Memory wait of 3 cycles, then PC_LdEn held low for 5 cycles -> Imem_addr stable for all 3 wait cycles; Instr/PC stable; Stall_cnt=5 (macro defined).
REQ-033 Wrap-around: RESET_PC=0xFFFF_FFFC, accept with PC_sel=0 -> next Imem_addr=0x0000_0000.
REQ-034 reset asserted mid-REQ, followed by Imem_ready pulsed in IDLE -> Imem_req=0 immediately; the pulse is ignored; the first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings,
// the sequential PC increment and the default reset fetch address.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_adder.sv
// Combinational next-PC: PC+4, or PC+4+(Immed<<2) for a taken branch.
// Arithmetic wraps modulo 2^32 and the result is always word aligned.
module fetch_pc_adder
    import fetch_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [31:0] Immed,
    input  logic        PC_sel,
    output logic [31:0] next_pc
);

    logic [31:0] offset;
    logic [31:0] sum;

    always_comb begin
        offset  = PC_sel ? (Immed << 2) : 32'd0;
        sum     = PC + PC_INCR + offset;
        next_pc = sum & ~32'h3;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: requests a word at PC, holds it for decode until
// accepted. Optional performance counters are enabled by FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        Clk,
    input  logic        reset,
    input  logic        PC_sel,
    input  logic [31:0] Immed,
    input  logic        PC_LdEn,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ready,
    input  logic [31:0] Imem_rdata,
    output logic [31:0] Instr,
    output logic        Instr_valid,
    output logic [31:0] PC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] Fetch_cnt,
    output logic [31:0] Stall_cnt
`endif
);

    localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         accept;
    logic         capture;
    logic [31:0]  next_pc;

    assign accept    = (state_q == HOLD) && PC_LdEn;
    assign capture   = (state_q == REQ) && Imem_ready;
    assign Imem_addr = PC;

    fetch_pc_adder u_pc_adder (
        .PC      (PC),
        .Immed   (Immed),
        .PC_sel  (PC_sel),
        .next_pc (next_pc)
    );

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (Imem_ready) state_d = HOLD;
            HOLD:    if (PC_LdEn) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Imem_req    = (state_q == REQ);
        Instr_valid = (state_q == HOLD);
    end

    // PC only moves on accept, so the request address stays put through waits.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            PC    <= START_PC;
            Instr <= 32'd0;
        end else begin
            if (accept) begin
                PC <= next_pc;
            end
            if (capture) begin
                Instr <= Imem_rdata;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            Fetch_cnt <= 32'd0;
            Stall_cnt <= 32'd0;
        end else begin
            if (accept && (Fetch_cnt != 32'hFFFF_FFFF)) begin
                Fetch_cnt <= Fetch_cnt + 32'd1;
            end
            if (Instr_valid && !PC_LdEn && (Stall_cnt != 32'hFFFF_FFFF)) begin
                Stall_cnt <= Stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        reset;
    logic        PC_sel;
    logic [31:0] Immed;
    logic        PC_LdEn;
    logic        Imem_ready;

    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic [31:0] Imem_rdata;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic [31:0] PC;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic        w_valid;
    logic [31:0] w_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] Fetch_cnt;
    logic [31:0] Stall_cnt;
    logic [31:0] w_fetch_cnt;
    logic [31:0] w_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state, expressed as fetch transactions rather than FSM states
    bit          m_starting;
    bit          m_waiting;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    assign Imem_rdata = mem_word(Imem_addr);
    assign w_rdata    = mem_word(w_addr);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .PC_sel      (PC_sel),
        .Immed       (Immed),
        .PC_LdEn     (PC_LdEn),
        .Imem_req    (Imem_req),
        .Imem_addr   (Imem_addr),
        .Imem_ready  (Imem_ready),
        .Imem_rdata  (Imem_rdata),
        .Instr       (Instr),
        .Instr_valid (Instr_valid),
        .PC          (PC)
`ifdef FETCH_PERF_CNT_EN
        ,
        .Fetch_cnt   (Fetch_cnt),
        .Stall_cnt   (Stall_cnt)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk         (Clk),
        .reset       (reset),
        .PC_sel      (PC_sel),
        .Immed       (Immed),
        .PC_LdEn     (PC_LdEn),
        .Imem_req    (w_req),
        .Imem_addr   (w_addr),
        .Imem_ready  (Imem_ready),
        .Imem_rdata  (w_rdata),
        .Instr       (w_instr),
        .Instr_valid (w_valid),
        .PC          (w_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .Fetch_cnt   (w_fetch_cnt),
        .Stall_cnt   (w_stall_cnt)
`endif
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic model_reset();
        m_starting = 1'b1;
        m_waiting  = 1'b0;
        m_valid    = 1'b0;
        m_pc       = 32'h0000_0000;
        m_instr    = 32'd0;
        m_fetch    = 32'd0;
        m_stall    = 32'd0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else if (m_starting) begin
            m_starting = 1'b0;
            m_waiting  = 1'b1;
        end else if (m_waiting) begin
            if (Imem_ready) begin
                m_waiting = 1'b0;
                m_valid   = 1'b1;
                m_instr   = mem_word(m_pc);
            end
        end else if (m_valid) begin
            if (PC_LdEn) begin
                m_pc      = (m_pc + 32'd4 + (PC_sel ? Immed * 32'd4 : 32'd0)) & 32'hFFFF_FFFC;
                m_valid   = 1'b0;
                m_waiting = 1'b1;
                if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 32'd1;
            end else if (m_stall != 32'hFFFF_FFFF) begin
                m_stall = m_stall + 32'd1;
            end
        end
    endtask

    task automatic checkOutput();
        check32("imem_req",    {31'd0, Imem_req},    {31'd0, m_waiting});
        check32("instr_valid", {31'd0, Instr_valid}, {31'd0, m_valid});
        check32("pc",          PC,                   m_pc);
        check32("instr",       Instr,                m_instr);
        if (m_waiting) check32("imem_addr", Imem_addr, m_pc);
`ifdef FETCH_PERF_CNT_EN
        check32("fetch_cnt", Fetch_cnt, m_fetch);
        check32("stall_cnt", Stall_cnt, m_stall);
`endif
    endtask

    task automatic applyStimulus(input logic ready, input logic ld_en,
                                 input logic sel, input logic [31:0] imm);
        Imem_ready = ready;
        PC_LdEn    = ld_en;
        PC_sel     = sel;
        Immed      = imm;
        @(posedge Clk);
        model_edge();
        #1;
        checkOutput();
    endtask

    initial begin
        logic [31:0] imm;
        reset      = 1'b0;
        Imem_ready = 1'b0;
        PC_LdEn    = 1'b0;
        PC_sel     = 1'b0;
        Immed      = 32'd0;
        model_reset();

        // Reset state, with a stray ready that must be ignored
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        check32("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);

        // Release: request one cycle later, data the cycle after with zero wait
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        check32("first_req", {31'd0, Imem_req}, 32'd1);
        check32("first_addr", Imem_addr, 32'h0000_0000);
        check32("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        check32("first_valid", {31'd0, Instr_valid}, 32'd1);
        check32("first_instr", Instr, mem_word(32'h0));

        // Sequential run 0, 4, 8, 12
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
            check32("seq_addr", Imem_addr, 32'(i * 4));
            if (i == 1) check32("wrap_addr", w_addr, 32'h0000_0000);
            applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
            check32("seq_instr", Instr, mem_word(32'(i * 4)));
        end

        // Forward branch from 12 to 0x100, then backward branch to 0x0FC
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd60);
        check32("branch_fwd_addr", Imem_addr, 32'h0000_0100);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        check32("branch_back_addr", Imem_addr, 32'h0000_00FC);

        // Three wait cycles, then five cycles of decode stall
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, $urandom);
            check32("wait_addr", Imem_addr, 32'h0000_00FC);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b1, $urandom);
            check32("stall_pc", PC, 32'h0000_00FC);
            check32("stall_instr", Instr, mem_word(32'h0000_00FC));
        end
`ifdef FETCH_PERF_CNT_EN
        check32("stall_cnt_5", Stall_cnt, 32'd5);
        check32("fetch_cnt_5", Fetch_cnt, 32'd5);
`endif

        // Reset in the middle of an outstanding request
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check32("async_req", {31'd0, Imem_req}, 32'd0);
        check32("async_valid", {31'd0, Instr_valid}, 32'd0);
        check32("async_pc", PC, 32'h0000_0000);
        check32("async_instr", Instr, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        check32("late_ready_addr", Imem_addr, 32'h0000_0000);
        check32("late_ready_instr", Instr, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            imm = ($urandom_range(0, 3) != 0) ? (32'($urandom_range(0, 64)) - 32'd32) : $urandom;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), imm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
